// File: rtl/ysyx_23060208_rd_arbiter_pkg.sv
// Shared encodings for the IFU/LSU read-channel arbiter: FSM states,
// one-hot grant values, owner pointer values and the AXI OKAY response.
package ysyx_23060208_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_AR   = 2'd1,
    ARB_R    = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_IFU  = 2'b01;
  localparam logic [1:0] GRANT_LSU  = 2'b10;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Round-robin pick: on a tie the master that was not served last wins.
  function automatic logic [1:0] arb_pick(input logic ifu_req,
                                          input logic lsu_req,
                                          input logic last_owner);
    if (ifu_req && lsu_req)
      return (last_owner == OWNER_LSU) ? GRANT_IFU : GRANT_LSU;
    else if (ifu_req)
      return GRANT_IFU;
    else if (lsu_req)
      return GRANT_LSU;
    else
      return GRANT_NONE;
  endfunction

endpackage

// File: rtl/ysyx_23060208_rd_arbiter.sv
// Two-master read-channel arbiter: IFU and LSU share one memory read port,
// one whole AR+R transaction at a time, round-robin on ties.
//
// state    | meaning
// ARB_IDLE | no owner; pick a winner from the pending arvalids
// ARB_AR   | owner's AR fields routed to mem until mem_arready
// ARB_R    | mem R beats routed to owner until the rlast handshake
module ysyx_23060208_rd_arbiter
  import ysyx_23060208_rd_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clock,
  input  logic                      reset,

  input  logic                      ifu_arvalid,
  input  logic [DATA_WIDTH-1:0]     ifu_araddr,
  input  logic [7:0]                ifu_arlen,
  input  logic [3:0]                ifu_arid,
  input  logic [2:0]                ifu_arsize,
  input  logic [1:0]                ifu_arburst,
  output logic                      ifu_arready,
  input  logic                      ifu_rready,
  output logic                      ifu_rvalid,
  output logic [2*DATA_WIDTH-1:0]   ifu_rdata,
  output logic [1:0]                ifu_rresp,
  output logic                      ifu_rlast,
  output logic [3:0]                ifu_rid,

  input  logic                      lsu_arvalid,
  input  logic [DATA_WIDTH-1:0]     lsu_araddr,
  input  logic [7:0]                lsu_arlen,
  input  logic [3:0]                lsu_arid,
  input  logic [2:0]                lsu_arsize,
  input  logic [1:0]                lsu_arburst,
  output logic                      lsu_arready,
  input  logic                      lsu_rready,
  output logic                      lsu_rvalid,
  output logic [2*DATA_WIDTH-1:0]   lsu_rdata,
  output logic [1:0]                lsu_rresp,
  output logic                      lsu_rlast,
  output logic [3:0]                lsu_rid,

  output logic                      mem_arvalid,
  output logic [DATA_WIDTH-1:0]     mem_araddr,
  output logic [7:0]                mem_arlen,
  output logic [3:0]                mem_arid,
  output logic [2:0]                mem_arsize,
  output logic [1:0]                mem_arburst,
  input  logic                      mem_arready,
  input  logic                      mem_rvalid,
  input  logic [2*DATA_WIDTH-1:0]   mem_rdata,
  input  logic [1:0]                mem_rresp,
  input  logic                      mem_rlast,
  input  logic [3:0]                mem_rid,
  output logic                      mem_rready,

  output logic [1:0]                grant
);

  arb_state_t state, state_nxt;
  logic [1:0] grant_nxt;
  logic       last_owner, last_owner_nxt;
  logic       own_ifu, own_lsu;
  logic       in_ar, in_r;

  assign own_ifu = (grant == GRANT_IFU);
  assign own_lsu = (grant == GRANT_LSU);
  assign in_ar   = (state == ARB_AR);
  assign in_r    = (state == ARB_R);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      grant      <= GRANT_NONE;
      last_owner <= OWNER_LSU;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_owner_nxt = last_owner;
    case (state)
      ARB_IDLE: begin
        grant_nxt = arb_pick(ifu_arvalid, lsu_arvalid, last_owner);
        if (ifu_arvalid || lsu_arvalid)
          state_nxt = ARB_AR;
      end
      ARB_AR: begin
        if (mem_arvalid && mem_arready)
          state_nxt = ARB_R;
      end
      ARB_R: begin
        // Only the final beat releases the port; earlier beats keep ownership.
        if (mem_rvalid && mem_rready && mem_rlast) begin
          state_nxt      = ARB_IDLE;
          grant_nxt      = GRANT_NONE;
          last_owner_nxt = own_lsu ? OWNER_LSU : OWNER_IFU;
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
        grant_nxt = GRANT_NONE;
      end
    endcase
  end

  always_comb begin
    mem_arvalid = 1'b0;
    mem_araddr  = '0;
    mem_arlen   = '0;
    mem_arid    = '0;
    mem_arsize  = '0;
    mem_arburst = '0;
    if (in_ar) begin
      if (own_lsu) begin
        mem_arvalid = lsu_arvalid;
        mem_araddr  = lsu_araddr;
        mem_arlen   = lsu_arlen;
        mem_arid    = lsu_arid;
        mem_arsize  = lsu_arsize;
        mem_arburst = lsu_arburst;
      end else if (own_ifu) begin
        mem_arvalid = ifu_arvalid;
        mem_araddr  = ifu_araddr;
        mem_arlen   = ifu_arlen;
        mem_arid    = ifu_arid;
        mem_arsize  = ifu_arsize;
        mem_arburst = ifu_arburst;
      end
    end
  end

  assign ifu_arready = in_ar && own_ifu && mem_arready;
  assign lsu_arready = in_ar && own_lsu && mem_arready;

  // R beats are forwarded untouched: no id filtering, faults pass through.
  always_comb begin
    ifu_rvalid = 1'b0;
    ifu_rdata  = '0;
    ifu_rresp  = RESP_OKAY;
    ifu_rlast  = 1'b0;
    ifu_rid    = '0;
    lsu_rvalid = 1'b0;
    lsu_rdata  = '0;
    lsu_rresp  = RESP_OKAY;
    lsu_rlast  = 1'b0;
    lsu_rid    = '0;
    mem_rready = 1'b0;
    if (in_r) begin
      if (own_ifu) begin
        ifu_rvalid = mem_rvalid;
        ifu_rdata  = mem_rdata;
        ifu_rresp  = mem_rresp;
        ifu_rlast  = mem_rlast;
        ifu_rid    = mem_rid;
        mem_rready = ifu_rready;
      end else if (own_lsu) begin
        lsu_rvalid = mem_rvalid;
        lsu_rdata  = mem_rdata;
        lsu_rresp  = mem_rresp;
        lsu_rlast  = mem_rlast;
        lsu_rid    = mem_rid;
        mem_rready = lsu_rready;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_rd_arbiter.sv
// Self-checking bench for the IFU/LSU read arbiter: behavioural slave,
// per-master expected-beat queues, a vector table plus corner sequences.
module tb_ysyx_23060208_rd_arbiter;
  import ysyx_23060208_rd_arbiter_pkg::*;

  localparam int DW = 32;

  logic clock, reset;

  logic ifu_arvalid, ifu_arready, ifu_rready, ifu_rvalid, ifu_rlast;
  logic [DW-1:0] ifu_araddr;
  logic [7:0] ifu_arlen;
  logic [3:0] ifu_arid, ifu_rid;
  logic [2:0] ifu_arsize;
  logic [1:0] ifu_arburst, ifu_rresp;
  logic [2*DW-1:0] ifu_rdata;

  logic lsu_arvalid, lsu_arready, lsu_rready, lsu_rvalid, lsu_rlast;
  logic [DW-1:0] lsu_araddr;
  logic [7:0] lsu_arlen;
  logic [3:0] lsu_arid, lsu_rid;
  logic [2:0] lsu_arsize;
  logic [1:0] lsu_arburst, lsu_rresp;
  logic [2*DW-1:0] lsu_rdata;

  logic mem_arvalid, mem_arready, mem_rvalid, mem_rlast, mem_rready;
  logic [DW-1:0] mem_araddr;
  logic [7:0] mem_arlen;
  logic [3:0] mem_arid, mem_rid;
  logic [2:0] mem_arsize;
  logic [1:0] mem_arburst, mem_rresp;
  logic [2*DW-1:0] mem_rdata;
  logic [1:0] grant;

  ysyx_23060208_rd_arbiter #(.DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arlen(ifu_arlen),
    .ifu_arid(ifu_arid), .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst),
    .ifu_arready(ifu_arready), .ifu_rready(ifu_rready), .ifu_rvalid(ifu_rvalid),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast), .ifu_rid(ifu_rid),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arlen(lsu_arlen),
    .lsu_arid(lsu_arid), .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst),
    .lsu_arready(lsu_arready), .lsu_rready(lsu_rready), .lsu_rvalid(lsu_rvalid),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast), .lsu_rid(lsu_rid),
    .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arlen(mem_arlen),
    .mem_arid(mem_arid), .mem_arsize(mem_arsize), .mem_arburst(mem_arburst),
    .mem_arready(mem_arready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_rresp(mem_rresp), .mem_rlast(mem_rlast), .mem_rid(mem_rid),
    .mem_rready(mem_rready), .grant(grant)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [3:0]  id;
    logic [1:0]  resp;
  } beat_t;

  typedef struct {
    bit          ifu_v;
    bit          lsu_v;
    logic [31:0] ifu_addr;
    logic [31:0] lsu_addr;
    logic [7:0]  len;
    logic [1:0]  g1;
    logic [1:0]  g2;
  } vec_t;

  beat_t ifu_q[$];
  beat_t lsu_q[$];
  vec_t  vecs[6];

  int n_pass = 0;
  int n_total = 0;

  int   cfg_gap = 0;
  logic [1:0] cfg_resp = 2'b00;

  bit sl_busy = 0;
  logic [31:0] sl_addr;
  logic [7:0]  sl_len, sl_beat;
  logic [3:0]  sl_id;
  int sl_gap = 0;

  logic s_ar_hs, s_r_hs, s_rlast_hs, s_ifu_arhs, s_lsu_arhs, s_rst;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [3:0]  s_arid;

  function automatic logic [63:0] beat_data(input logic [31:0] a, input logic [7:0] b);
    return {a ^ 32'h5A5A_5A5A, a + {24'h0, b}};
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic issue(input bit m, input logic [31:0] addr, input logic [7:0] len,
                       input logic [3:0] id);
    beat_t b;
    for (int i = 0; i <= int'(len); i++) begin
      b.data = beat_data(addr, 8'(i));
      b.last = (i == int'(len));
      b.id   = id;
      b.resp = cfg_resp;
      if (m) lsu_q.push_back(b);
      else   ifu_q.push_back(b);
    end
    if (m) begin
      lsu_arvalid = 1'b1; lsu_araddr = addr; lsu_arlen = len; lsu_arid = id;
      lsu_arsize = 3'd3; lsu_arburst = 2'b01;
    end else begin
      ifu_arvalid = 1'b1; ifu_araddr = addr; ifu_arlen = len; ifu_arid = id;
      ifu_arsize = 3'd2; ifu_arburst = 2'b01;
    end
  endtask

  task automatic sb_pop(input bit m, input logic [70:0] act);
    beat_t e;
    if (m) begin
      check("lsu_beat_expected", lsu_q.size() > 0, 1);
      if (lsu_q.size() > 0) begin
        e = lsu_q.pop_front();
        check("lsu_beat", act, {e.data, e.last, e.id, e.resp});
      end
    end else begin
      check("ifu_beat_expected", ifu_q.size() > 0, 1);
      if (ifu_q.size() > 0) begin
        e = ifu_q.pop_front();
        check("ifu_beat", act, {e.data, e.last, e.id, e.resp});
      end
    end
  endtask

  task automatic sl_present();
    mem_rvalid = 1'b1;
    mem_rdata  = beat_data(sl_addr, sl_beat);
    mem_rlast  = (sl_beat == sl_len);
    mem_rid    = sl_id;
    mem_rresp  = cfg_resp;
  endtask

  // Called at a negedge: sample, cross one posedge, drive, return at next negedge.
  task automatic cycle();
    #1;
    s_ar_hs    = mem_arvalid && mem_arready;
    s_r_hs     = mem_rvalid && mem_rready;
    s_rlast_hs = s_r_hs && mem_rlast;
    s_ifu_arhs = ifu_arvalid && ifu_arready;
    s_lsu_arhs = lsu_arvalid && lsu_arready;
    s_rst      = reset;
    s_araddr   = mem_araddr;
    s_arlen    = mem_arlen;
    s_arid     = mem_arid;
    if (ifu_rvalid && ifu_rready) sb_pop(1'b0, {ifu_rdata, ifu_rlast, ifu_rid, ifu_rresp});
    if (lsu_rvalid && lsu_rready) sb_pop(1'b1, {lsu_rdata, lsu_rlast, lsu_rid, lsu_rresp});
    @(posedge clock);
    #1;
    if (s_ifu_arhs) ifu_arvalid = 1'b0;
    if (s_lsu_arhs) lsu_arvalid = 1'b0;
    if (!s_rst) begin
      sl_busy = 0; mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0;
      mem_rdata = '0; mem_rid = '0; mem_rresp = '0;
    end else if (!sl_busy) begin
      mem_arready = 1'b1;
      if (s_ar_hs) begin
        sl_busy = 1; mem_arready = 1'b0;
        sl_addr = s_araddr; sl_len = s_arlen; sl_id = s_arid; sl_beat = 8'd0; sl_gap = 0;
        sl_present();
      end
    end else if (s_r_hs) begin
      if (mem_rlast) begin
        sl_busy = 0; mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_arready = 1'b1;
      end else begin
        sl_beat = sl_beat + 8'd1;
        sl_gap = cfg_gap;
        if (sl_gap == 0) sl_present();
        else mem_rvalid = 1'b0;
      end
    end else if (!mem_rvalid) begin
      if (sl_gap > 0) sl_gap--;
      if (sl_gap == 0) sl_present();
    end
    @(negedge clock);
  endtask

  task automatic wait_rlast(input string nm);
    bit seen = 0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (s_rlast_hs) begin
        seen = 1;
        break;
      end
    end
    check({nm, "_rlast_seen"}, seen, 1);
  endtask

  task automatic check_ar(input string nm, input logic [1:0] g, input logic [31:0] addr,
                          input logic [7:0] len);
    logic [3:0] id;
    logic [2:0] sz;
    id = (g == GRANT_LSU) ? 4'h2 : 4'h1;
    sz = (g == GRANT_LSU) ? 3'd3 : 3'd2;
    check({nm, "_grant"}, grant, g);
    check({nm, "_ar"}, {mem_arvalid, mem_araddr, mem_arlen, mem_arid, mem_arsize, mem_arburst},
          {1'b1, addr, len, id, sz, 2'b01});
  endtask

  initial begin
    reset = 1'b0;
    ifu_arvalid = 0; ifu_araddr = '0; ifu_arlen = '0; ifu_arid = '0; ifu_arsize = '0;
    ifu_arburst = '0; ifu_rready = 1'b1;
    lsu_arvalid = 0; lsu_araddr = '0; lsu_arlen = '0; lsu_arid = '0; lsu_arsize = '0;
    lsu_arburst = '0; lsu_rready = 1'b1;
    mem_arready = 0; mem_rvalid = 0; mem_rdata = '0; mem_rresp = '0; mem_rlast = 0; mem_rid = '0;

    vecs[0] = '{1, 1, 32'h8000_0000, 32'h8000_1000, 8'd0, GRANT_IFU, GRANT_LSU};
    vecs[1] = '{1, 1, 32'h8000_0040, 32'h8000_1040, 8'd0, GRANT_IFU, GRANT_LSU};
    vecs[2] = '{1, 0, 32'h8000_0000, 32'h0,         8'd0, GRANT_IFU, GRANT_NONE};
    vecs[3] = '{1, 1, 32'h8000_0080, 32'h8000_1080, 8'd1, GRANT_LSU, GRANT_IFU};
    vecs[4] = '{0, 1, 32'h0,         32'h8000_10C0, 8'd1, GRANT_LSU, GRANT_NONE};
    vecs[5] = '{1, 1, 32'h8000_0100, 32'h8000_1100, 8'd2, GRANT_IFU, GRANT_LSU};

    @(negedge clock);
    repeat (3) cycle();
    check("rst_grant", grant, GRANT_NONE);
    check("rst_valids", {mem_arvalid, mem_rready, ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid},
          6'b0);
    check("rst_data", {mem_araddr, ifu_rdata, lsu_rdata}, '0);
    reset = 1'b1;
    cycle();

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].ifu_v) issue(1'b0, vecs[v].ifu_addr, vecs[v].len, 4'h1);
      if (vecs[v].lsu_v) issue(1'b1, vecs[v].lsu_addr, vecs[v].len, 4'h2);
      cycle();
      check_ar("vec_first", vecs[v].g1,
               (vecs[v].g1 == GRANT_LSU) ? vecs[v].lsu_addr : vecs[v].ifu_addr, vecs[v].len);
      wait_rlast("vec_first");
      check("vec_idle_grant", {grant, mem_arvalid}, {GRANT_NONE, 1'b0});
      if (vecs[v].g2 != GRANT_NONE) begin
        cycle();
        check_ar("vec_second", vecs[v].g2,
                 (vecs[v].g2 == GRANT_LSU) ? vecs[v].lsu_addr : vecs[v].ifu_addr, vecs[v].len);
        wait_rlast("vec_second");
        check("vec_done_grant", grant, GRANT_NONE);
      end
      cycle();
    end

    // LSU burst with gapped beats while the IFU asks mid-burst
    cfg_gap = 2;
    issue(1'b1, 32'h8000_2000, 8'd3, 4'h2);
    cycle();
    check_ar("burst", GRANT_LSU, 32'h8000_2000, 8'd3);
    cycle();
    issue(1'b0, 32'h8000_4000, 8'd0, 4'h1);
    begin
      bit seen = 0;
      for (int i = 0; i < 40; i++) begin
        check("burst_grant_hold", grant, GRANT_LSU);
        check("burst_ifu_arready", ifu_arready, 1'b0);
        cycle();
        if (s_rlast_hs) begin
          seen = 1;
          break;
        end
      end
      check("burst_rlast_seen", seen, 1);
    end
    check("burst_beats_drained", lsu_q.size(), 0);
    check("burst_idle_grant", grant, GRANT_NONE);
    cycle();
    check_ar("late_ifu", GRANT_IFU, 32'h8000_4000, 8'd0);
    wait_rlast("late_ifu");
    cfg_gap = 0;
    cycle();

    // owner backpressure with the slave holding a beat
    issue(1'b0, 32'h8000_6000, 8'd1, 4'h1);
    cycle();
    ifu_rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_hold", {mem_rready, ifu_rvalid, lsu_rvalid}, 3'b010);
    end
    ifu_rready = 1'b1;
    wait_rlast("bp");
    check("bp_beats_drained", ifu_q.size(), 0);
    cycle();

    // fault response and id pass through to the IFU
    cfg_resp = 2'b11;
    issue(1'b0, 32'h8000_7000, 8'd0, 4'h3);
    cycle();
    cycle();
    check("fault_beat", {ifu_rvalid, ifu_rresp, ifu_rid}, {1'b1, 2'b11, 4'h3});
    wait_rlast("fault");
    cfg_resp = 2'b00;
    cycle();

    // reset in the middle of an LSU read; last owner was the IFU
    issue(1'b1, 32'h8000_5000, 8'd3, 4'h2);
    lsu_rready = 1'b0;
    cycle();
    cycle();
    check("mid_rst_pre", {grant, lsu_rvalid}, {GRANT_LSU, 1'b1});
    reset = 1'b0;
    cycle();
    check("mid_rst_grant", grant, GRANT_NONE);
    check("mid_rst_valids", {mem_arvalid, mem_rready, ifu_rvalid, lsu_rvalid, lsu_arready},
          5'b0);
    reset = 1'b1;
    lsu_rready = 1'b1;
    lsu_q.delete();
    cycle();
    issue(1'b0, 32'h8000_0200, 8'd0, 4'h1);
    issue(1'b1, 32'h8000_1200, 8'd0, 4'h2);
    cycle();
    check_ar("post_rst_tie", GRANT_IFU, 32'h8000_0200, 8'd0);
    wait_rlast("post_rst_first");
    cycle();
    check_ar("post_rst_second", GRANT_LSU, 32'h8000_1200, 8'd0);
    wait_rlast("post_rst_second");
    cycle();

    check("final_queues_empty", {ifu_q.size(), lsu_q.size()}, 64'd0);
    check("final_grant", grant, GRANT_NONE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
